// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
//   DEF_FIFO_D / DEF_FIFO_W : default depth (entries) and data width (bits)
//   ptr_width()             : pointer width for a given depth (index bits + wrap bit)
//   fifo_status_t           : bundle of the FIFO status flags
package fifo_pkg;

  localparam int unsigned DEF_FIFO_D = 8;
  localparam int unsigned DEF_FIFO_W = 32;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO_D x FIFO_W register array, one write port and one
// synchronous read port.
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data loads mem[rd_addr] at the edge
//   rd_addr  in   read index
//   rd_data  out  registered read data, holds when rd_en is low
// The array itself is not reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_D = DEF_FIFO_D,
  parameter int unsigned FIFO_W = DEF_FIFO_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(FIFO_D)-1:0]  wr_addr,
  input  logic [FIFO_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(FIFO_D)-1:0]  rd_addr,
  output logic [FIFO_W-1:0]          rd_data
);

  logic [FIFO_W-1:0] mem [FIFO_D];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and sticky error flags.
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   write_en     in   write request
//   data_in      in   write data [FIFO_W]
//   read_en      in   read request
//   data_out     out  registered read data, valid one cycle after the read
//   empty        out  count == 0
//   full         out  count == FIFO_D
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  occupancy [$clog2(FIFO_D)+1]
//   overflow     out  sticky: a write was rejected
//   underflow    out  sticky: a read was rejected
//   clr_err      in   synchronous clear of overflow/underflow (a new error wins)
// Optional: define FIFO_ASSERT_EN to embed concurrent protocol assertions.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_D    = DEF_FIFO_D,
  parameter int unsigned FIFO_W    = DEF_FIFO_W,
  parameter int unsigned AF_THRESH = FIFO_D - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_en,
  input  logic [FIFO_W-1:0]         data_in,
  input  logic                      read_en,
  output logic [FIFO_W-1:0]         data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(FIFO_D):0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int unsigned PW = ptr_width(FIFO_D);
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  if (FIFO_D < 2 || (FIFO_D & (FIFO_D - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: FIFO_D must be a power of 2 and at least 2");
  end

  logic [PW-1:0] front_ptr;
  logic [PW-1:0] end_ptr;
  logic [PW-1:0] occ;
  logic          ovf_q;
  logic          unf_q;
  logic          wr_ok;
  logic          rd_ok;
  fifo_status_t  status;

  // Accept decisions use pre-edge state; a full FIFO still takes a write
  // when a read frees the slot in the same cycle.
  always_comb begin
    wr_ok = write_en && (!status.full || read_en);
    rd_ok = read_en && !status.empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_ptr <= '0;
      end_ptr   <= '0;
    end else begin
      if (wr_ok) begin
        end_ptr <= end_ptr + 1'b1;
      end
      if (rd_ok) begin
        front_ptr <= front_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write_en && !wr_ok) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
      if (read_en && !rd_ok) begin
        unf_q <= 1'b1;
      end else if (clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

  // Flags decode from the registered pointers only.
  always_comb begin
    occ                 = end_ptr - front_ptr;
    status              = '0;
    status.empty        = (front_ptr == end_ptr);
    status.full         = (front_ptr[PW-2:0] == end_ptr[PW-2:0]) &&
                          (front_ptr[PW-1] != end_ptr[PW-1]);
    status.almost_full  = (occ >= AF_T);
    status.almost_empty = (occ <= AE_T);
    status.overflow     = ovf_q;
    status.underflow    = unf_q;
  end

  always_comb begin
    count        = occ;
    empty        = status.empty;
    full         = status.full;
    almost_full  = status.almost_full;
    almost_empty = status.almost_empty;
    overflow     = status.overflow;
    underflow    = status.underflow;
  end

  fifo_mem #(
    .FIFO_D (FIFO_D),
    .FIFO_W (FIFO_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_addr (end_ptr[PW-2:0]),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (front_ptr[PW-2:0]),
    .rd_data (data_out)
  );

`ifdef FIFO_ASSERT_EN
  // First sampled edge after release still sees the reset state.
  a_reset_vals: assert property (@(posedge clk) disable iff (!reset_n)
      $rose(reset_n) |-> (front_ptr == '0 && end_ptr == '0 && count == '0 &&
                          empty && almost_empty && !full && !almost_full &&
                          !overflow && !underflow && data_out == '0))
    $info("%0t a_reset_vals pass", $time);
    else $error("%0t a_reset_vals fail", $time);

  a_not_both: assert property (@(posedge clk) disable iff (!reset_n)
      !(empty && full))
    $info("%0t a_not_both pass", $time);
    else $error("%0t a_not_both fail", $time);

  a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
      count <= PW'(FIFO_D))
    $info("%0t a_count_max pass", $time);
    else $error("%0t a_count_max fail", $time);

  a_no_wr_adv: assert property (@(posedge clk) disable iff (!reset_n)
      (write_en && !wr_ok) |=> (end_ptr == $past(end_ptr)))
    $info("%0t a_no_wr_adv pass", $time);
    else $error("%0t a_no_wr_adv fail", $time);

  a_no_rd_adv: assert property (@(posedge clk) disable iff (!reset_n)
      (read_en && !rd_ok) |=> (front_ptr == $past(front_ptr)))
    $info("%0t a_no_rd_adv pass", $time);
    else $error("%0t a_no_rd_adv fail", $time);

  a_count_track: assert property (@(posedge clk) disable iff (!reset_n)
      1'b1 |=> (count == $past(count) + PW'($past(wr_ok)) - PW'($past(rd_ok))))
    $info("%0t a_count_track pass", $time);
    else $error("%0t a_count_track fail", $time);
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: self-checking bench for sync_fifo_param (8 x 32,
// AF_THRESH=6, AE_THRESH=2). Table-driven fill/drain vectors, hand-written
// corner sequences and a randomized phase against a queue-based model.
module tb_sync_fifo_param;

  localparam int unsigned D = 8;

  logic        clk;
  logic        reset_n;
  logic        write_en;
  logic [31:0] data_in;
  logic        read_en;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  sync_fifo_param #(
    .FIFO_D    (8),
    .FIFO_W    (32),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Behavioural model: stored words in arrival order plus flag state.
  logic [31:0] mq[$];
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] m_dout;

  typedef struct {
    logic        we;
    logic        re;
    logic        clr;
    logic [31:0] din;
    int unsigned cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        unf;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic re, logic clr, logic [31:0] din,
                              int unsigned cnt, logic fl, logic em, logic af,
                              logic ae, logic ovf, logic unf, logic [31:0] dout);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.din = din; v.cnt = cnt;
    v.full = fl; v.empty = em; v.af = af; v.ae = ae;
    v.ovf = ovf; v.unf = unf; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1ns after the edge.
  task automatic step(input logic we, input logic [31:0] din, input logic re, input logic clr);
    logic wok, rok;
    write_en = we; data_in = din; read_en = re; clr_err = clr;
    wok = we && ((mq.size() != D) || re);
    rok = re && (mq.size() != 0);
    if (rok) m_dout = mq.pop_front();
    if (wok) mq.push_back(din);
    m_ovf = (we && !wok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (re && !rok) ? 1'b1 : (clr ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
    write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".count"},        64'(count),        64'(mq.size()));
    chk({tag, ".full"},         64'(full),         64'(mq.size() == D));
    chk({tag, ".empty"},        64'(empty),        64'(mq.size() == 0));
    chk({tag, ".almost_full"},  64'(almost_full),  64'(mq.size() >= 6));
    chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(mq.size() <= 2));
    chk({tag, ".overflow"},     64'(overflow),     64'(m_ovf));
    chk({tag, ".underflow"},    64'(underflow),    64'(m_unf));
    chk({tag, ".data_out"},     64'(data_out),     64'(m_dout));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".empty"},        64'(empty),         64'd1);
    chk({tag, ".full"},         64'(full),          64'd0);
    chk({tag, ".count"},        64'(count),         64'd0);
    chk({tag, ".almost_empty"}, 64'(almost_empty),  64'd1);
    chk({tag, ".almost_full"},  64'(almost_full),   64'd0);
    chk({tag, ".overflow"},     64'(overflow),      64'd0);
    chk({tag, ".underflow"},    64'(underflow),     64'd0);
    chk({tag, ".data_out"},     64'(data_out),      64'd0);
    chk({tag, ".front_ptr"},    64'(dut.front_ptr), 64'd0);
    chk({tag, ".end_ptr"},      64'(dut.end_ptr),   64'd0);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
  endfunction

  initial begin
    logic        we, re, clr;
    logic [31:0] d;
    int unsigned wbias;

    reset_n = 1'b0; write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0; data_in = '0;
    model_reset();

    // Fill, overflow, drain, underflow, clear: fixed expectations.
    //        we re clr din  cnt full em af ae ovf unf dout
    vt.push_back(mk(1, 0, 0, 32'h1, 1, 0, 0, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h2, 2, 0, 0, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h3, 3, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h4, 4, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h5, 5, 0, 0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h6, 6, 0, 0, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h7, 7, 0, 0, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h8, 8, 1, 0, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 32'h9, 8, 1, 0, 1, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 1, 0, 32'h0, 7, 0, 0, 1, 0, 1, 0, 32'h1));
    vt.push_back(mk(0, 1, 0, 32'h0, 6, 0, 0, 1, 0, 1, 0, 32'h2));
    vt.push_back(mk(0, 1, 0, 32'h0, 5, 0, 0, 0, 0, 1, 0, 32'h3));
    vt.push_back(mk(0, 1, 0, 32'h0, 4, 0, 0, 0, 0, 1, 0, 32'h4));
    vt.push_back(mk(0, 1, 0, 32'h0, 3, 0, 0, 0, 0, 1, 0, 32'h5));
    vt.push_back(mk(0, 1, 0, 32'h0, 2, 0, 0, 0, 1, 1, 0, 32'h6));
    vt.push_back(mk(0, 1, 0, 32'h0, 1, 0, 0, 0, 1, 1, 0, 32'h7));
    vt.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 0, 1, 1, 0, 32'h8));
    vt.push_back(mk(0, 1, 0, 32'h0, 0, 0, 1, 0, 1, 1, 1, 32'h8));
    vt.push_back(mk(0, 0, 1, 32'h0, 0, 0, 1, 0, 1, 0, 0, 32'h8));

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    reset_n = 1'b1;

    // Table-driven phase
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].we, vt[i].din, vt[i].re, vt[i].clr);
      chk($sformatf("vec%0d.count", i),        64'(count),        64'(vt[i].cnt));
      chk($sformatf("vec%0d.full", i),         64'(full),         64'(vt[i].full));
      chk($sformatf("vec%0d.empty", i),        64'(empty),        64'(vt[i].empty));
      chk($sformatf("vec%0d.almost_full", i),  64'(almost_full),  64'(vt[i].af));
      chk($sformatf("vec%0d.almost_empty", i), 64'(almost_empty), 64'(vt[i].ae));
      chk($sformatf("vec%0d.overflow", i),     64'(overflow),     64'(vt[i].ovf));
      chk($sformatf("vec%0d.underflow", i),    64'(underflow),    64'(vt[i].unf));
      chk($sformatf("vec%0d.data_out", i),     64'(data_out),     64'(vt[i].dout));
    end

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    chk("full_rw.count",    64'(count),    64'd8);
    chk("full_rw.full",     64'(full),     64'd1);
    chk("full_rw.overflow", 64'(overflow), 64'd0);
    chk("full_rw.data_out", 64'(data_out), 64'h10);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("full_rw.last", 64'(data_out), 64'hA5);
    cmp_model("full_rw_drained");

    // Simultaneous read+write while empty
    step(1'b1, 32'h5A, 1'b1, 1'b0);
    chk("empty_rw.count",     64'(count),     64'd1);
    chk("empty_rw.underflow", 64'(underflow), 64'd1);
    chk("empty_rw.data_out",  64'(data_out),  64'hA5);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("empty_rw.readback",  64'(data_out),  64'h5A);

    // Clear, then clear coinciding with a new overflow
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr.underflow", 64'(underflow), 64'd0);
    chk("clr.overflow",  64'(overflow),  64'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("clr_vs_set.overflow", 64'(overflow), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_after.overflow",  64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    cmp_model("clr_drained");

    // Wrap: 20 interleaved write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hC000 + 32'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("wrap%0d.data_out", i), 64'(data_out), 64'(32'hC000 + 32'(i)));
    end
    cmp_model("wrap_end");

    // Randomized traffic with alternating write/read bias
    for (int seg = 0; seg < 6; seg++) begin
      wbias = (seg % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 100; i++) begin
        we  = ($urandom_range(0, 99) < wbias);
        re  = ($urandom_range(0, 99) >= wbias);
        if ($urandom_range(0, 4) == 0) re = 1'b1;
        clr = ($urandom_range(0, 15) == 0);
        d   = $urandom;
        step(we, d, re, clr);
        cmp_model($sformatf("rnd%0d_%0d", seg, i));
      end
    end

    // Reset mid-operation, asserted between clock edges
    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("midrst.entry0",  64'(dut.u_mem.mem[0]), 64'h77);
    chk("midrst.end_ptr", 64'(dut.end_ptr),      64'd1);
    cmp_model("midrst_wr");
    step(1'b0, '0, 1'b1, 1'b0);
    chk("midrst.readback", 64'(data_out), 64'h77);
    cmp_model("midrst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
